// File: rtl/grey_scan_if.sv
// grey_scan_if -- bus bundle between the display scanner and its environment.
//   SEL    [5:0]  mode control: [0] freeze, [1] single-digit, [5:2] digit index
//   DIGITS [59:0] twelve 5-bit Gray digits, digit 11 at [59:55] .. digit 0 at [4:0]
//   IO_OUT [7:0]  registered pad bus: [6:0] segments gfedcba, [7] frame marker
interface grey_scan_if;
  logic [5:0]  SEL;
  logic [59:0] DIGITS;
  logic [7:0]  IO_OUT;

  modport master (output SEL, output DIGITS, input IO_OUT);
  modport slave  (input SEL, input DIGITS, output IO_OUT);
endinterface

// File: rtl/grey_scan.sv
// grey_scan -- time-multiplexed 7-segment scanner for the grey decade counter.
// Snapshots the twelve Gray digits once per frame (SNAP), then shows each
// digit for DWELL cycles, most significant first (SCAN). SINGLE shows one
// live digit chosen by SEL[5:2].
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-low reset
//   bus  grey_scan_if.slave (SEL, DIGITS in; IO_OUT out)
// Parameter: DWELL (1..255) cycles per digit.
// Build option: define GREY_SCAN_LZB_EN for leading-zero blanking in SCAN.
module grey_scan #(
  parameter int unsigned DWELL = 4
) (
  input logic        CLK,
  input logic        RST,
  grey_scan_if.slave bus
);

  localparam logic [1:0] SNAP   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] SINGLE = 2'd2;

  localparam logic [3:0] IDX_TOP    = 4'd11;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [59:0] snap_q, snap_d;
  logic [7:0]  out_q, out_d;

  function automatic logic [4:0] pick(input logic [59:0] d, input logic [3:0] i);
    logic [4:0] r;
    r = '0;
    for (int unsigned j = 0; j < 12; j++)
      if (4'(j) == i) r = d[j*5 +: 5];
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [4:0] g);
    logic [4:0] b;
    logic [6:0] s;
    b[4] = g[4];
    for (int unsigned k = 0; k < 4; k++)
      b[3-k] = b[4-k] ^ g[3-k];
    case (b)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

`ifdef GREY_SCAN_LZB_EN
  // Blank when every digit from i upward is zero; digit 0 always shows.
  // Gray 00000 is the only encoding of binary 0, so invalid codes count as non-zero.
  function automatic logic lead_zero(input logic [59:0] d, input logic [3:0] i);
    logic z;
    z = 1'b1;
    for (int unsigned j = 0; j < 12; j++)
      if (j >= 32'(i) && d[j*5 +: 5] != 5'd0) z = 1'b0;
    return z && (i != 4'd0);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    snap_d  = snap_q;
    out_d   = '0;

    if (bus.SEL[1]) begin
      state_d = SINGLE;
    end else begin
      case (state_q)
        SNAP: begin
          if (!bus.SEL[0]) snap_d = bus.DIGITS;
          state_d = SCAN;
          idx_d   = IDX_TOP;
          dwell_d = '0;
        end
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (idx_q == 4'd0) state_d = SNAP;
            else               idx_d   = idx_q - 4'd1;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
        default: begin
          state_d = SNAP;
          idx_d   = IDX_TOP;
          dwell_d = '0;
        end
      endcase
    end

    // IO_OUT is registered, so it is decoded from the next-state values;
    // this makes the digit appear on the same edge that selects it.
    case (state_d)
      SCAN: begin
        out_d[7] = (idx_d == IDX_TOP);
`ifdef GREY_SCAN_LZB_EN
        out_d[6:0] = lead_zero(snap_d, idx_d) ? 7'h00 : seg(pick(snap_d, idx_d));
`else
        out_d[6:0] = seg(pick(snap_d, idx_d));
`endif
      end
      SINGLE: begin
        out_d[7]   = 1'b1;
        out_d[6:0] = (bus.SEL[5:2] > IDX_TOP) ? 7'h00 : seg(pick(bus.DIGITS, bus.SEL[5:2]));
      end
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= SNAP;
      idx_q   <= IDX_TOP;
      dwell_q <= '0;
      snap_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      snap_q  <= snap_d;
      out_q   <= out_d;
    end
  end

  assign bus.IO_OUT = out_q;

endmodule
